unified_mem_arbiter: RTL

Shares one single-ported unified memory between the processor's instruction-fetch side and its load/store side. Each requester holds a request until it receives a one-cycle done pulse carrying read data. Arbitration is round-robin, and memory wait states are handled through a ready handshake. A timeout guard stops a missing memory response from hanging the multicycle controller forever.

---
 rtl/unified_mem_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter that shares one single-ported memory between the
// instruction-fetch side (I) and the load/store side (D).
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | sample requests and grant one side, then register the access
//   BUSY  | mem_req held with stable address and data, waiting for mem_ready
//   RESP  | one-cycle done pulse to the owner; requests are not sampled
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iReq,
    input  logic [ADDR_W-1:0] iAddr,
    output logic [DATA_W-1:0] iRdata,
    output logic              iDone,
    input  logic              dRead,
    input  logic              dWrite,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    output logic [DATA_W-1:0] dRdata,
    output logic              dDone,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              bus_err
);

    // TIMEOUT-1 always fits in clog2(TIMEOUT) bits for TIMEOUT >= 2
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state, state_nxt;
    logic             owner_d;   // 1 = D side owns the current access
    logic             last_d;    // 1 = D side was granted last
    logic [CNT_W-1:0] to_cnt;
    logic             d_req;
    logic             grant_any;
    logic             grant_d;
    logic             done_ok;
    logic             done_to;

    assign d_req     = dRead | dWrite;
    assign grant_any = iReq | d_req;
    // On a tie the side that did not win last time is granted
    assign grant_d   = d_req & (~iReq | ~last_d);
    assign done_ok   = (state == BUSY) & mem_ready;
    assign done_to   = (state == BUSY) & ~mem_ready & (to_cnt == CNT_LAST);
    assign busy      = (state != IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = BUSY;
            BUSY:    if (done_ok || done_to) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Access registers, timeout counter, read-data capture and done pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_d   <= 1'b0;
            last_d    <= 1'b1;
            to_cnt    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            iRdata    <= '0;
            dRdata    <= '0;
            iDone     <= 1'b0;
            dDone     <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            iDone <= 1'b0;
            dDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner_d  <= grant_d;
                        last_d   <= grant_d;
                        mem_req  <= 1'b1;
                        mem_we   <= grant_d & dWrite;
                        mem_addr <= grant_d ? dAddr : iAddr;
                        to_cnt   <= '0;
                        if (grant_d) mem_wdata <= dWdata;
                    end
                end
                BUSY: begin
                    if (done_ok || done_to) begin
                        mem_req <= 1'b0;
                        to_cnt  <= '0;
                        if (owner_d) dDone <= 1'b1;
                        else         iDone <= 1'b1;
                        if (done_to) begin
                            // An aborted access returns zero rather than stale data
                            bus_err <= 1'b1;
                            if (owner_d) dRdata <= '0;
                            else         iRdata <= '0;
                        end else if (!mem_we) begin
                            if (owner_d) dRdata <= mem_rdata;
                            else         iRdata <= mem_rdata;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
